arb_mux_n: RTL and testbench
============================

# arb_mux_n

Parametrised N-to-1 arbitrating multiplexer with valid/ready handshakes and one registered output stage. It generalises the pipeline's fixed-select combinational muxes to a shared resource with N requesters, e.g. IF and LSU requests merged onto one memory port. Selection is by round-robin or fixed priority, not by an external select. The block sits between requester stages and a single downstream consumer.

## Interface
- N, default 3: number of input channels; legal range 2..16.
- WIDTH, default 24: payload width per channel.
- PRIO_MODE, default ARB_RR: ARB_RR selects round-robin; ARB_FIXED gives channel 0 the highest priority.
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_flush, input, 1: synchronous flush of the output stage.
- i_valid, input, N: per-channel request valid.
- i_data, input, N×WIDTH: packed payloads; channel k occupies bits [k*WIDTH +: WIDTH].
- o_ready, output, N: per-channel accept, combinational; a transfer on channel k occurs when i_valid[k] && o_ready[k].
- o_valid, output, 1: output register holds a payload.
- o_data, output, WIDTH: registered payload.
- o_idx, output, IDX_W = $clog2(N): index of the source channel of o_data.
- i_ready, input, 1: downstream accept; a transfer occurs when o_valid && i_ready.

## Operation
- load_en = !i_flush && (!o_valid || i_ready).
- Grant is one-hot over the set of channels with i_valid high.
  - ARB_FIXED: grant goes to the lowest-index requester.
  - ARB_RR: search starts at ptr and runs ptr, ptr+1, … modulo N; the first requester found wins.
- o_ready[k] = load_en && grant[k]. At most one bit of o_ready is high. When load_en is 0, all bits are 0.
- On a clock edge where load_en is 1 and at least one channel is granted:
  - o_data ← i_data of the winner.
  - o_idx ← winner index.
  - o_valid ← 1.
  - ptr ← (winner+1) mod N; the wrap from N-1 goes to 0.
- On a clock edge where load_en is 1 and no channel requests: o_valid ← 0. o_data and o_idx hold their values.
- On a clock edge where i_flush is 1:
  - o_valid ← 0.
  - No channel is granted and no input transfer occurs.
  - ptr, o_data and o_idx hold their values.
  - Flush takes priority over both a simultaneous downstream accept and a simultaneous new grant.
- ptr exists only in ARB_RR mode. In ARB_FIXED mode it is unused and held at 0.
- o_ready must not combinationally depend on o_valid of other instances. It may depend on i_valid and i_ready.
- The block tolerates an upstream that drops i_valid without a transfer; no request is latched before it is granted.

## Timing
- Reset (i_rst_n low, asynchronous): o_valid=0, o_data=0, o_idx=0, ptr=0. o_ready is all-zero while in reset.
- Latency: a payload accepted on edge t appears on o_valid/o_data after edge t, i.e. 1 cycle.
- Throughput: 1 transfer per cycle under continuous i_ready=1. A simultaneous output accept and new load on the same edge is required (no bubble).
- Backpressure: while o_valid && !i_ready, the output register is stable and o_ready is all-zero.
- Fairness (ARB_RR): with all N channels continuously valid and i_ready=1, the grant order is k, k+1, …, wrapping modulo N. No channel waits more than N-1 grants.
- Reset deassertion mid-stream: the first grant after reset uses ptr=0.

## Structure
- Package arb_pkg:
  - typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e.
  - localparam helper for IDX_W.
- Sub-module rr_arbiter: parameters N and PRIO_MODE; inputs i_req[N], i_ptr; outputs o_grant (one-hot) and o_grant_idx. It is purely combinational, implemented as a double-width rotate and priority-encode.
- arb_mux_n contains the pointer register, the output register and the handshake logic.

## Test plan
- Reset, then all i_valid=0, i_ready=1 → o_valid=0, o_data=0, o_idx=0, o_ready=000 on every cycle.
- N=3, ARB_RR, all valid continuously, data 0xA/0xB/0xC on channels 0/1/2, i_ready=1 → o_idx sequence 0,1,2,0,1,… and o_data sequence 0xA,0xB,0xC,…, one per cycle, with no gaps.
- Same stimulus with ARB_FIXED → o_idx stays 0 every cycle; o_ready=001 throughout.
- Channel 2 only valid, i_ready=0 for 3 cycles after the first load → o_valid=1, o_data=0xC held stable, o_ready=000. i_ready=1 on cycle 4 → transfer, then the next load the same cycle.
- o_valid=1, then i_flush=1 together with i_ready=1 and channel 1 valid → next cycle o_valid=0, no transfer on channel 1, ptr unchanged.
- Assert i_rst_n=0 asynchronously mid-stream with o_valid=1 → o_valid drops immediately without waiting for a clock edge. After release, the first grant with all channels valid goes to channel 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbitrating N-to-1 multiplexer.
package arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Index width for an N-channel arbiter; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: rotate the request vector by the pointer,
// take the lowest set bit, then rotate the winner index back.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int        N         = 3,
  parameter arb_mode_e PRIO_MODE = ARB_RR,
  localparam int       IDX_W     = idx_w(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic [IDX_W-1:0] eff_ptr;
  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] offset;
  logic             found;
  logic [IDX_W:0]   idx_sum;

  // Fixed priority is round-robin with the search always starting at 0.
  assign eff_ptr = (PRIO_MODE == ARB_RR) ? i_ptr : '0;

  // Double-width rotate, priority encode, and map the offset back to a channel.
  always_comb begin
    req_dbl     = {i_req, i_req} >> eff_ptr;
    req_rot     = req_dbl[N-1:0];
    offset      = '0;
    found       = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        offset = k[IDX_W-1:0];
        found  = 1'b1;
      end
    end
    idx_sum = {1'b0, offset} + {1'b0, eff_ptr};
    if (idx_sum >= (IDX_W+1)'(N)) begin
      idx_sum = idx_sum - (IDX_W+1)'(N);
    end
    o_grant_idx = idx_sum[IDX_W-1:0];
    o_grant     = '0;
    if (found) begin
      o_grant[o_grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-to-1 arbitrating multiplexer with valid/ready handshakes and a single
// registered output stage. Holds the round-robin pointer and output register.
module arb_mux_n
  import arb_pkg::*;
#(
  parameter int        N         = 3,
  parameter int        WIDTH     = 24,
  parameter arb_mode_e PRIO_MODE = ARB_RR,
  localparam int       IDX_W     = idx_w(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic [N-1:0]       i_valid,
  input  logic [N*WIDTH-1:0] i_data,
  output logic [N-1:0]       o_ready,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [IDX_W-1:0]   o_idx,
  input  logic               i_ready
);

  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q,  o_data_d;
  logic [IDX_W-1:0] o_idx_q,   o_idx_d;
  logic [IDX_W-1:0] ptr_q,     ptr_d;

  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             load_en;
  logic             any_req;

  rr_arbiter #(
    .N         (N),
    .PRIO_MODE (PRIO_MODE)
  ) u_rr_arbiter (
    .i_req       (i_valid),
    .i_ptr       (ptr_q),
    .o_grant     (grant),
    .o_grant_idx (grant_idx)
  );

  // Output stage can take a new payload when empty or draining this cycle;
  // flush blocks loading. Reset gates o_ready so nothing is accepted in reset.
  always_comb begin
    load_en = !i_flush && (!o_valid_q || i_ready);
    any_req = |i_valid;
    o_ready = (i_rst_n && load_en) ? grant : '0;
  end

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_idx_d   = o_idx_q;
    ptr_d     = ptr_q;
    if (i_flush) begin
      o_valid_d = 1'b0;
    end else if (load_en) begin
      if (any_req) begin
        o_valid_d = 1'b1;
        o_data_d  = i_data[grant_idx*WIDTH +: WIDTH];
        o_idx_d   = grant_idx;
        if (PRIO_MODE == ARB_RR) begin
          ptr_d = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        o_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_idx_q   <= '0;
      ptr_q     <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_idx_q   <= o_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_idx   = o_idx_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: one round-robin and one fixed-priority instance driven
// by the same stimulus, each checked against a behavioural model.
module tb_arb_mux_n;
  import arb_pkg::*;

  localparam int N  = 3;
  localparam int W  = 24;
  localparam int IW = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           rdy   = 1'b1;
  logic [N-1:0]   vld   = '0;
  logic [N*W-1:0] data  = '0;

  logic [N-1:0]  ordy [2];
  logic          ov   [2];
  logic [W-1:0]  od   [2];
  logic [IW-1:0] oidx [2];

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  int          m_ov  [2];
  int          m_idx [2];
  int          m_ptr [2];
  logic [W-1:0] m_od [2];

  always #5 clk = ~clk;

  arb_mux_n #(.N(N), .WIDTH(W), .PRIO_MODE(ARB_RR)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vld), .i_data(data),
    .o_ready(ordy[0]), .o_valid(ov[0]), .o_data(od[0]), .o_idx(oidx[0]), .i_ready(rdy)
  );

  arb_mux_n #(.N(N), .WIDTH(W), .PRIO_MODE(ARB_FIXED)) dut_fx (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vld), .i_data(data),
    .o_ready(ordy[1]), .o_valid(ov[1]), .o_data(od[1]), .o_idx(oidx[1]), .i_ready(rdy)
  );

  function automatic string nm(input int m);
    return (m == 0) ? "rr" : "fx";
  endfunction

  function automatic bit m_load_en(input int m);
    return !flush && (m_ov[m] == 0 || rdy);
  endfunction

  // Channel granted this cycle by the spec rules, or -1 when none.
  function automatic int m_winner(input int m);
    int start;
    start = (m == 0) ? m_ptr[m] : 0;
    if (!m_load_en(m)) return -1;
    for (int j = 0; j < N; j++) begin
      if (vld[(start + j) % N]) return (start + j) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ov[m] = 0; m_od[m] = '0; m_idx[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic chk_outputs();
    for (int m = 0; m < 2; m++) begin
      chk({nm(m), " o_valid"}, 32'(ov[m]), 32'(m_ov[m]));
      chk({nm(m), " o_data"},  32'(od[m]), 32'(m_od[m]));
      chk({nm(m), " o_idx"},   32'(oidx[m]), 32'(m_idx[m]));
    end
  endtask

  // One clock: check o_ready against the model, advance the model, check outputs.
  task automatic cycle();
    int w;
    #1;
    for (int m = 0; m < 2; m++) begin
      w = m_winner(m);
      chk({nm(m), " o_ready"}, 32'(ordy[m]), (w >= 0) ? (32'd1 << w) : 32'd0);
    end
    for (int m = 0; m < 2; m++) begin
      w = m_winner(m);
      if (flush) begin
        m_ov[m] = 0;
      end else if (m_load_en(m)) begin
        if (w >= 0) begin
          m_ov[m]  = 1;
          m_od[m]  = data[w*W +: W];
          m_idx[m] = w;
          if (m == 0) m_ptr[m] = (w + 1) % N;
        end else begin
          m_ov[m] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  initial begin
    model_reset();
    // In reset with requests present: nothing accepted, outputs cleared.
    vld  = 3'b111;
    data = {24'h00000C, 24'h00000B, 24'h00000A};
    #3;
    for (int m = 0; m < 2; m++) chk({nm(m), " reset o_ready"}, 32'(ordy[m]), 32'd0);
    chk_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    vld   = '0;

    // Idle: no requests, downstream ready.
    for (int i = 0; i < 3; i++) cycle();

    // All channels valid, continuous drain.
    vld = 3'b111;
    for (int i = 0; i < 7; i++) cycle();

    // Channel 2 alone with backpressure for three cycles.
    vld = 3'b100;
    cycle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rdy = 1'b1;
    cycle();

    // Flush collides with downstream accept and a channel-1 request.
    vld = 3'b010;
    cycle();
    flush = 1'b1;
    vld   = 3'b010;
    cycle();
    flush = 1'b0;
    vld   = 3'b111;
    for (int i = 0; i < 3; i++) cycle();

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      vld   = N'($urandom_range(0, 7));
      rdy   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < N; k++) data[k*W +: W] = W'($urandom);
      cycle();
    end
    flush = 1'b0;
    rdy   = 1'b1;

    // Asynchronous reset mid-stream with a non-zero pointer.
    vld = 3'b001;
    cycle();
    vld = 3'b111;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      chk({nm(m), " async o_valid"}, 32'(ov[m]), 32'd0);
      chk({nm(m), " async o_ready"}, 32'(ordy[m]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
